mem_port_arbiter: RTL and testbench

Shares the single-ported, registered-output program/data RAM between the CPU's instruction-fetch path and the memory stage's LDR/STR path. It grants at most one RAM access per cycle, with data accesses normally having priority. It tags each granted read and returns the RAM output to the owning requester exactly one cycle later. It sits between the controller/datapath and the RAM macro, and replaces the direct RAM hookup.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data (LDR/STR) paths, with 1-cycle tagged read return.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_run;
    logic   w_force_if;
    logic   r_rd_pend;
    logic   r_rd_owner;

    if (MAX_DATA_BURST < 1) begin : g_param_check
        $error("MAX_DATA_BURST must be at least 1");
    end

    // NOTE: state lives in always_ff with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // Grants are gated by rst so nothing is accepted while reset is held.
    assign w_run = (r_state == ST_RUN) && !rst;

`ifdef ARB_STARVE_GUARD_EN
    localparam int                CNT_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DATA_BURST);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force_if = if_req && (r_starve_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || if_gnt || !if_req) r_starve_cnt <= '0;
        else if (d_gnt)               r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
`else
    assign w_force_if = 1'b0;
`endif

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_run) begin
            if (d_req && !w_force_if) d_gnt  = 1'b1;
            else if (if_req)          if_gnt = 1'b1;
        end
        if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (if_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = if_addr;
        end
    end

    // Read tag: which requester owns the RAM output arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend  <= if_gnt || (d_gnt && !d_we);
            r_rd_owner <= d_gnt;
        end
    end

    // A read outstanding when rst rises is dropped in that same cycle.
    assign if_rvalid = r_rd_pend && !r_rd_owner && !rst;
    assign d_rvalid  = r_rd_pend &&  r_rd_owner && !rst;
    assign if_rdata  = ram_rdata;
    assign d_rdata   = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Starvation expectations follow ARB_STARVE_GUARD_EN when the bench is built with the same define.
module tb_mem_port_arbiter;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, ram_en, ram_we;
    logic [DW-1:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] init_word(int a);
        return 32'hC0DE_0000 ^ 32'(a * 7919);
    endfunction

    // Registered-output RAM macro behaviour
    logic [DW-1:0] mem     [0:2047];
    bit            wr_done [0:2047];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                wr_done[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= wr_done[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
            end
        end
    end

    // Transaction-level reference model
    logic [DW-1:0] ref_mem [int];
    int            m_since_rst = 0;
    int            m_burst     = 0;
    bit            m_pend      = 0;
    bit            m_owner_d   = 0;
    logic [DW-1:0] m_data      = '0;

    bit            e_if_gnt, e_d_gnt, e_ram_en, e_ram_we, e_if_rv, e_d_rv;
    logic [AW-1:0] e_ram_addr;
    logic [DW-1:0] e_ram_wdata, e_rdata;

    function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(int'(a));
    endfunction

    task automatic model_eval();
        bit run, forced;
        run = !rst && (m_since_rst >= 1);
`ifdef ARB_STARVE_GUARD_EN
        forced = if_req && (m_burst >= MAXB);
`else
        forced = 1'b0;
`endif
        e_d_gnt     = run && d_req && !forced;
        e_if_gnt    = run && if_req && !e_d_gnt;
        e_ram_en    = e_d_gnt || e_if_gnt;
        e_ram_we    = e_d_gnt && d_we;
        e_ram_addr  = e_d_gnt ? d_addr : (e_if_gnt ? if_addr : '0);
        e_ram_wdata = e_d_gnt ? d_wdata : '0;
        e_if_rv     = !rst && m_pend && !m_owner_d;
        e_d_rv      = !rst && m_pend && m_owner_d;
        e_rdata     = m_data;
    endtask

    task automatic model_adv();
        if (rst) begin
            m_since_rst = 0;
            m_pend      = 0;
            m_owner_d   = 0;
            m_burst     = 0;
        end else begin
            if (m_since_rst < 1000) m_since_rst++;
            m_pend    = e_if_gnt || (e_d_gnt && !d_we);
            m_owner_d = e_d_gnt;
            m_data    = ref_rd(e_ram_addr);
            if (e_ram_we) ref_mem[int'(d_addr)] = d_wdata;
            if (e_if_gnt || !if_req) m_burst = 0;
            else if (e_d_gnt)        m_burst++;
        end
    endtask

    task automatic drive(bit ir, int ia, bit dr, bit dw, int da, logic [DW-1:0] wd);
        if_req  = ir;
        if_addr = AW'(ia);
        d_req   = dr;
        d_we    = dw;
        d_addr  = AW'(da);
        d_wdata = wd;
    endtask

    task automatic tick_eval();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick_adv();
        model_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5, 1, 0, 9, '0);
        for (int i = 0; i < 2; i++) begin
            tick_eval();
            n_tot++; if ({if_gnt, d_gnt, ram_en, ram_we, if_rvalid, d_rvalid} !== 6'b0)
                $display("FAIL reset_outputs got %b want 000000", {if_gnt, d_gnt, ram_en, ram_we, if_rvalid, d_rvalid});
            else n_pass++;
            tick_adv();
        end
        rst = 1'b0;
        drive(1, 5, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_gnt !== 1'b0) $display("FAIL init_no_gnt got %b want 0", if_gnt); else n_pass++;
        tick_adv();
        tick_eval();
        n_tot++; if (if_gnt !== 1'b1 || ram_addr !== 11'd5)
            $display("FAIL first_fetch_gnt got gnt=%b addr=%0d want gnt=1 addr=5", if_gnt, ram_addr);
        else n_pass++;
        tick_adv();
        drive(0, 0, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(5))
            $display("FAIL first_fetch_data got v=%b %h want v=1 %h", if_rvalid, if_rdata, init_word(5));
        else n_pass++;
        tick_adv();
    endtask

    task automatic test_contention();
        drive(1, 3, 1, 0, 9, '0);
        tick_eval();
        n_tot++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0)
            $display("FAIL contend_gnt got d=%b i=%b want d=1 i=0", d_gnt, if_gnt);
        else n_pass++;
        tick_adv();
        drive(1, 3, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (d_rvalid !== 1'b1 || d_rdata !== ref_rd(9) || if_rvalid !== 1'b0)
            $display("FAIL contend_d_ret got v=%b %h want v=1 %h", d_rvalid, d_rdata, ref_rd(9));
        else n_pass++;
        n_tot++; if (if_gnt !== 1'b1 || ram_addr !== 11'd3)
            $display("FAIL contend_if_after got gnt=%b addr=%0d want 1/3", if_gnt, ram_addr);
        else n_pass++;
        tick_adv();
        drive(0, 0, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_rvalid !== 1'b1 || if_rdata !== ref_rd(3))
            $display("FAIL contend_if_ret got v=%b %h want v=1 %h", if_rvalid, if_rdata, ref_rd(3));
        else n_pass++;
        tick_adv();
    endtask

    task automatic test_store();
        drive(0, 0, 1, 1, 7, 32'hDEAD_BEEF);
        tick_eval();
        n_tot++; if (ram_we !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 11'd7 || ram_wdata !== 32'hDEAD_BEEF)
            $display("FAIL store_drive got en=%b we=%b addr=%0d wd=%h want 1/1/7/deadbeef",
                     ram_en, ram_we, ram_addr, ram_wdata);
        else n_pass++;
        tick_adv();
        drive(1, 7, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || ram_we !== 1'b0)
            $display("FAIL store_no_rvalid got dv=%b iv=%b we=%b want 0/0/0", d_rvalid, if_rvalid, ram_we);
        else n_pass++;
        tick_adv();
        drive(0, 0, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF)
            $display("FAIL store_readback got v=%b %h want v=1 deadbeef", if_rvalid, if_rdata);
        else n_pass++;
        tick_adv();
    endtask

    task automatic test_starvation();
        int n_if = 0;
        bit exp_i;
        drive(0, 0, 0, 0, 0, '0);
        tick_eval(); tick_adv();
        for (int k = 0; k < 15; k++) begin
            drive(1, 20 + k, 1, 0, 40 + k, '0);
            tick_eval();
`ifdef ARB_STARVE_GUARD_EN
            exp_i = (k % (MAXB + 1)) == MAXB;
`else
            exp_i = 1'b0;
`endif
            n_tot++; if (if_gnt !== exp_i || d_gnt !== !exp_i)
                $display("FAIL starve_k%0d got i=%b d=%b want i=%b d=%b", k, if_gnt, d_gnt, exp_i, !exp_i);
            else n_pass++;
            if (if_gnt) n_if++;
            tick_adv();
        end
`ifdef ARB_STARVE_GUARD_EN
        n_tot++; if (n_if !== 3) $display("FAIL starve_count got %0d want 3", n_if); else n_pass++;
`else
        n_tot++; if (n_if !== 0) $display("FAIL starve_count got %0d want 0", n_if); else n_pass++;
`endif
        drive(0, 0, 0, 0, 0, '0);
        tick_eval(); tick_adv();
    endtask

    task automatic test_interleave();
        drive(1, 1, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_gnt !== 1'b1) $display("FAIL ilv_i1_gnt got %b want 1", if_gnt); else n_pass++;
        tick_adv();
        drive(0, 0, 1, 0, 2, '0);
        tick_eval();
        n_tot++; if (d_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== ref_rd(1))
            $display("FAIL ilv_d2 got g=%b iv=%b %h want 1/1 %h", d_gnt, if_rvalid, if_rdata, ref_rd(1));
        else n_pass++;
        tick_adv();
        drive(1, 3, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_gnt !== 1'b1 || d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== ref_rd(2))
            $display("FAIL ilv_i3 got g=%b dv=%b iv=%b %h want 1/1/0 %h",
                     if_gnt, d_rvalid, if_rvalid, d_rdata, ref_rd(2));
        else n_pass++;
        tick_adv();
        drive(0, 0, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== ref_rd(3))
            $display("FAIL ilv_ret3 got iv=%b dv=%b %h want 1/0 %h", if_rvalid, d_rvalid, if_rdata, ref_rd(3));
        else n_pass++;
        tick_adv();
    endtask

    task automatic test_reset_mid_read();
        drive(1, 11, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_gnt !== 1'b1) $display("FAIL rmr_gnt got %b want 1", if_gnt); else n_pass++;
        tick_adv();
        rst = 1'b1;
        drive(1, 11, 0, 0, 0, '0);
        tick_eval();
        n_tot++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_gnt !== 1'b0)
            $display("FAIL rmr_dropped got iv=%b dv=%b g=%b want 0/0/0", if_rvalid, d_rvalid, if_gnt);
        else n_pass++;
        tick_adv();
        rst = 1'b0;
        tick_eval();
        n_tot++; if (if_rvalid !== 1'b0 || if_gnt !== 1'b0)
            $display("FAIL rmr_init got iv=%b g=%b want 0/0", if_rvalid, if_gnt);
        else n_pass++;
        tick_adv();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
            tick_eval();
            n_tot++;
            if (if_gnt !== e_if_gnt || d_gnt !== e_d_gnt || ram_en !== e_ram_en || ram_we !== e_ram_we ||
                ram_addr !== e_ram_addr || ram_wdata !== e_ram_wdata ||
                if_rvalid !== e_if_rv || d_rvalid !== e_d_rv) begin
                if (errs < 10)
                    $display("FAIL rand_c%0d got ig=%b dg=%b en=%b we=%b a=%0d wd=%h iv=%b dv=%b want %b %b %b %b %0d %h %b %b",
                             c, if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata, if_rvalid, d_rvalid,
                             e_if_gnt, e_d_gnt, e_ram_en, e_ram_we, e_ram_addr, e_ram_wdata, e_if_rv, e_d_rv);
                errs++;
            end else n_pass++;
            if (e_if_rv || e_d_rv) begin
                n_tot++;
                if ((e_if_rv && if_rdata !== e_rdata) || (e_d_rv && d_rdata !== e_rdata)) begin
                    if (errs < 10)
                        $display("FAIL rand_data_c%0d got if=%h d=%h want %h", c, if_rdata, d_rdata, e_rdata);
                    errs++;
                end else n_pass++;
            end
            tick_adv();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0);
        test_reset();
        test_contention();
        test_store();
        test_starvation();
        test_interleave();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
